// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch stage feeding the IF/ID register.
// FETCH_MISALIGN_TRAP_EN: misaligned redirect enters a sticky fault instead of being aligned.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        fetch_fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {BOOT, RUN, STALL, FLUSH, FAULT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        advance;

  assign imem_addr = pc;
  assign advance   = !id_valid || id_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q;
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= NOP;
      id_pc       <= 32'h0;
      id_pc_plus4 <= 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      case (state)
        BOOT: state <= RUN;
        // FLUSH always has id_valid low, so its exit edge fetches the redirect target.
        RUN, STALL, FLUSH: begin
          if (redirect_valid) begin
            id_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
              state   <= FAULT;
              fault_q <= 1'b1;
            end else begin
              pc    <= redirect_pc;
              state <= FLUSH;
            end
`else
            pc    <= redirect_pc & 32'hFFFF_FFFC;
            state <= FLUSH;
`endif
          end else if (advance) begin
            id_instr    <= imem_rd;
            id_pc       <= pc;
            id_pc_plus4 <= pc + 32'd4;
            id_valid    <= 1'b1;
            pc          <= pc + 32'd4;
            state       <= RUN;
          end else begin
            state <= STALL;
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule
